// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, reset/interrupt vectoring, branch redirect, stall
module if_fetch_stage #(
  parameter logic [3:0] TWO_BYTE_OPC = 4'hC,
  parameter logic [7:0] RST_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_en,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       intr,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic [7:0] imem_addr2,
  input  logic [7:0] imem_rdata2,
  output logic [7:0] instruction,
  output logic [7:0] data_B,
  output logic [7:0] pc_plus1,
  output logic [7:0] IP,
  output logic       fetch_valid,
  output logic       intr_ack
);

  typedef enum logic [1:0] {
    S_VEC_RST = 2'd0,
    S_RUN     = 2'd1,
    S_VEC_INT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] r_ip;
  logic       r_int_pend;
  logic       r_intr_ack;
  logic       w_take_int;
  logic       w_two_byte;
  logic [7:0] w_pc_seq;

  assign w_two_byte = (imem_rdata[7:4] == TWO_BYTE_OPC);
  assign w_pc_seq   = r_pc + (w_two_byte ? 8'd2 : 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_VEC_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Branch outranks a pending interrupt; vector fetch states ignore redirects and stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_take_int  = 1'b0;
    case (r_state)
      S_VEC_RST: begin
        w_pc_nxt    = imem_rdata;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          w_pc_nxt = branch_target;
        end else if (r_int_pend && pc_en) begin
          w_take_int  = 1'b1;
          w_state_nxt = S_VEC_INT;
        end else if (pc_en) begin
          w_pc_nxt = w_pc_seq;
        end
      end
      S_VEC_INT: begin
        w_pc_nxt    = imem_rdata;
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_VEC_RST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= 8'h00;
      r_int_pend <= 1'b0;
      r_ip       <= 8'h00;
      r_intr_ack <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_int_pend <= w_take_int ? 1'b0 : (intr | r_int_pend);
      r_ip       <= w_take_int ? r_pc : r_ip;
      r_intr_ack <= w_take_int;
    end
  end

  always_comb begin
    imem_addr   = r_pc;
    pc_plus1    = r_pc;
    fetch_valid = 1'b0;
    case (r_state)
      S_VEC_RST: imem_addr = RST_VEC_ADDR;
      S_VEC_INT: imem_addr = INT_VEC_ADDR;
      S_RUN: begin
        pc_plus1    = w_pc_seq;
        fetch_valid = ~r_int_pend;
      end
      default: imem_addr = RST_VEC_ADDR;
    endcase
    imem_addr2  = imem_addr + 8'd1;
    instruction = fetch_valid ? imem_rdata : 8'h00;
    data_B      = imem_rdata2;
    IP          = r_ip;
    intr_ack    = r_intr_ack;
  end

endmodule
